mem_port_arbiter: RTL and testbench

- Shares one single-port, word-addressed unified memory between the IF stage (instruction fetch) and the MEM stage (LW/SW).
- Owns a small FSM that grants one requester at a time and holds the memory request until the memory acknowledges.
- Generates the IF and MEM stall conditions that feed the PC/IR disable and pipeline-freeze logic.
- Honours IF-stage KILL so that squashed fetches never return data to the pipeline.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port word-addressed memory between instruction fetch and data access.
// Holds the granted request until ram_ack, produces stalls, honours fetch KILL and aborts hung accesses.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  output logic          if_stall,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_ready,
  output logic          mem_stall,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          ram_ack,
  output logic          err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_IF  = 2'd1;
  localparam logic [1:0] BUSY_MEM = 2'd2;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);

  logic [1:0]    state_reg, state_next;
  logic          ram_req_reg, ram_req_next;
  logic          ram_we_reg, ram_we_next;
  logic [AW-1:0] ram_addr_reg, ram_addr_next;
  logic [31:0]   ram_wdata_reg, ram_wdata_next;
  logic          err_reg, err_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          kill_pend_reg, kill_pend_next;

  logic mem_any, if_ok, grant_if, grant_mem, timeout_hit;

  assign mem_any     = mem_rd | mem_wr;
  assign if_ok       = if_req & ~if_kill;
  // A starved fetch overrides MEM priority, but a killed fetch is never granted.
  assign grant_if    = if_ok & (~mem_any | (starve_reg == SMAX));
  assign grant_mem   = mem_any & ~grant_if;
  assign timeout_hit = (TIMEOUT > 0) && (tcnt_reg == TLAST);

  always_comb begin
    state_next     = state_reg;
    ram_req_next   = ram_req_reg;
    ram_we_next    = ram_we_reg;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    err_next       = 1'b0;
    starve_next    = starve_reg;
    tcnt_next      = tcnt_reg;
    kill_pend_next = kill_pend_reg;
    case (state_reg)
      IDLE: begin
        if (grant_if) begin
          state_next    = BUSY_IF;
          ram_req_next  = 1'b1;
          ram_we_next   = 1'b0;
          ram_addr_next = if_addr;
          tcnt_next     = '0;
          starve_next   = '0;
        end else if (grant_mem) begin
          state_next     = BUSY_MEM;
          ram_req_next   = 1'b1;
          ram_we_next    = mem_wr;
          ram_addr_next  = mem_addr;
          ram_wdata_next = mem_wdata;
          tcnt_next      = '0;
          if (if_req && (starve_reg != SMAX))
            starve_next = starve_reg + 1'b1;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (ram_ack || timeout_hit) begin
          state_next     = IDLE;
          ram_req_next   = 1'b0;
          ram_we_next    = 1'b0;
          tcnt_next      = '0;
          kill_pend_next = 1'b0;
          err_next       = ~ram_ack;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
          if ((state_reg == BUSY_IF) && if_kill)
            kill_pend_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ram_req_reg   <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      err_reg       <= 1'b0;
      starve_reg    <= '0;
      tcnt_reg      <= '0;
      kill_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ram_req_reg   <= ram_req_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      err_reg       <= err_next;
      starve_reg    <= starve_next;
      tcnt_reg      <= tcnt_next;
      kill_pend_reg <= kill_pend_next;
    end
  end

  // Kill on the ack cycle itself suppresses the fetch just like an earlier one.
  assign if_ready  = (state_reg == BUSY_IF) & ram_ack & ~kill_pend_reg & ~if_kill;
  assign mem_ready = (state_reg == BUSY_MEM) & ram_ack;
  assign if_rdata  = if_ready ? ram_rdata : 32'd0;
  assign mem_rdata = mem_ready ? ram_rdata : 32'd0;
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_any & ~mem_ready;

  assign ram_req   = ram_req_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, arbitration, starvation, kill, store and timeout scenarios.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, mem_rd, mem_wr, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, ram_req, ram_we, err;
  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.AW(32), .TIMEOUT(16), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h10; if_kill = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    ram_ack = 1'b0; ram_rdata = '0;
    #1;
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", ram_req); end
    n_checks++; if (ram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
    n_checks++; if ({ram_we, err, if_ready, mem_ready} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {ram_we, err, if_ready, mem_ready}); end
    step(); reset = 1'b1; #1;
    n_checks++; if ({if_stall, ram_req} !== 2'b10) begin n_fail++; $display("FAIL idle_cycle: got %b want 10", {if_stall, ram_req}); end
    step();
    n_checks++; if ({ram_req, ram_we, ram_addr} !== {2'b10, 32'h10}) begin n_fail++; $display("FAIL fetch_grant: got req/we %b addr %h want 10 / 10", {ram_req, ram_we}, ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h2800_0000; #1;
    n_checks++; if ({if_ready, if_stall, if_rdata} !== {2'b10, 32'h2800_0000}) begin n_fail++; $display("FAIL fetch_ack: got rdy/stall %b data %h want 10 / 28000000", {if_ready, if_stall}, if_rdata); end
    step(); ram_ack = 1'b0; if_req = 1'b0; #1;
    n_checks++; if ({ram_req, if_ready} !== 2'b00) begin n_fail++; $display("FAIL fetch_done: got %b want 00", {ram_req, if_ready}); end
    $display("txn reset+fetch addr 10 complete");
  endtask

  task automatic test_arbitration();
    if_req = 1'b1; if_addr = 32'h20; mem_rd = 1'b1; mem_addr = 32'h100; #1;
    n_checks++; if ({if_stall, mem_stall} !== 2'b11) begin n_fail++; $display("FAIL arb_stalls: got %b want 11", {if_stall, mem_stall}); end
    step();
    n_checks++; if ({ram_req, ram_we, ram_addr} !== {2'b10, 32'h100}) begin n_fail++; $display("FAIL arb_mem_first: got %b addr %h want 10 / 100", {ram_req, ram_we}, ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h1111_1111; #1;
    n_checks++; if ({mem_ready, if_ready, if_stall, mem_rdata} !== {3'b101, 32'h1111_1111}) begin n_fail++; $display("FAIL arb_mem_ack: got %b data %h want 101 / 11111111", {mem_ready, if_ready, if_stall}, mem_rdata); end
    step(); ram_ack = 1'b0; mem_rd = 1'b0; #1;
    n_checks++; if ({ram_req, if_stall} !== 2'b01) begin n_fail++; $display("FAIL arb_gap: got %b want 01", {ram_req, if_stall}); end
    step();
    n_checks++; if (ram_addr !== 32'h20 || ram_req !== 1'b1) begin n_fail++; $display("FAIL arb_if_second: got addr %h req %b want 20 / 1", ram_addr, ram_req); end
    ram_ack = 1'b1; ram_rdata = 32'h2222_2222; #1;
    n_checks++; if ({if_ready, if_rdata, mem_rdata} !== {1'b1, 32'h2222_2222, 32'h0}) begin n_fail++; $display("FAIL arb_if_ack: got %b %h %h want 1 22222222 0", if_ready, if_rdata, mem_rdata); end
    step(); ram_ack = 1'b0; if_req = 1'b0;
    $display("txn arbitration mem 100 then if 20 complete");
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h20; mem_rd = 1'b1; mem_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (ram_addr !== 32'h200) begin n_fail++; $display("FAIL starve_mem_win%0d: got %h want 200", i, ram_addr); end
      ram_ack = 1'b1; ram_rdata = 32'h3000 + i; #1;
      n_checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'h3000 + i}) begin n_fail++; $display("FAIL starve_mem_ack%0d: got %b %h want 1 %h", i, mem_ready, mem_rdata, 32'h3000 + i); end
      step(); ram_ack = 1'b0;
    end
    step();
    n_checks++; if (ram_addr !== 32'h20) begin n_fail++; $display("FAIL starve_forced_if: got %h want 20", ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h4444; #1;
    n_checks++; if ({if_ready, mem_ready, mem_stall} !== 3'b101) begin n_fail++; $display("FAIL starve_if_ack: got %b want 101", {if_ready, mem_ready, mem_stall}); end
    step(); ram_ack = 1'b0; if_addr = 32'h24;
    step();
    n_checks++; if (ram_addr !== 32'h200) begin n_fail++; $display("FAIL starve_cleared: got %h want 200", ram_addr); end
    ram_ack = 1'b1; step(); ram_ack = 1'b0; mem_rd = 1'b0;
    step();
    n_checks++; if (ram_addr !== 32'h24) begin n_fail++; $display("FAIL starve_if_after: got %h want 24", ram_addr); end
    ram_ack = 1'b1; step(); ram_ack = 1'b0; if_req = 1'b0;
    $display("txn starvation 4 mem wins then forced if complete");
  endtask

  task automatic test_kill();
    if_req = 1'b1; if_addr = 32'h30;
    step();
    n_checks++; if (ram_addr !== 32'h30) begin n_fail++; $display("FAIL kill_grant: got %h want 30", ram_addr); end
    if_kill = 1'b1; step(); if_kill = 1'b0; step(); step();
    ram_ack = 1'b1; ram_rdata = 32'h3333; #1;
    n_checks++; if ({if_ready, if_stall, if_rdata} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL kill_suppress: got %b %h want 01 0", {if_ready, if_stall}, if_rdata); end
    step(); ram_ack = 1'b0; if_addr = 32'h34; #1;
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL kill_idle: got %b want 0", ram_req); end
    step();
    n_checks++; if (ram_addr !== 32'h34) begin n_fail++; $display("FAIL kill_regrant: got %h want 34", ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h3434; #1;
    n_checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h3434}) begin n_fail++; $display("FAIL kill_fresh: got %b %h want 1 3434", if_ready, if_rdata); end
    step(); ram_ack = 1'b0; if_addr = 32'h38;
    step();
    if_kill = 1'b1; ram_ack = 1'b1; ram_rdata = 32'h3838; #1;
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL kill_on_ack: got %b want 0", if_ready); end
    step(); if_kill = 1'b0; ram_ack = 1'b0; if_req = 1'b0;
    $display("txn kill fetch 30 and 38 squashed, 34 delivered");
  endtask

  task automatic test_store();
    mem_wr = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
    step(); mem_wdata = 32'h0BAD_0BAD;
    n_checks++; if ({ram_req, ram_we, ram_addr, ram_wdata} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL sw_grant: got %b %h %h want 11 40 deadbeef", {ram_req, ram_we}, ram_addr, ram_wdata); end
    step();
    n_checks++; if ({ram_we, ram_wdata, mem_stall} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL sw_hold: got %b %h %b want 1 deadbeef 1", ram_we, ram_wdata, mem_stall); end
    ram_ack = 1'b1; ram_rdata = 32'h55; #1;
    n_checks++; if ({mem_ready, mem_stall} !== 2'b10) begin n_fail++; $display("FAIL sw_ack: got %b want 10", {mem_ready, mem_stall}); end
    step(); ram_ack = 1'b0; mem_rd = 1'b1; mem_addr = 32'h44; mem_wdata = 32'h1234_5678; #1;
    n_checks++; if ({ram_req, ram_we} !== 2'b00) begin n_fail++; $display("FAIL sw_release: got %b want 00", {ram_req, ram_we}); end
    step();
    n_checks++; if ({ram_we, ram_wdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL rdwr_is_store: got %b %h want 1 12345678", ram_we, ram_wdata); end
    ram_ack = 1'b1; step(); ram_ack = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    $display("txn store 40 deadbeef and rd+wr 44 complete");
  endtask

  task automatic test_timeout();
    int busy = 0;
    int errs = 0;
    mem_rd = 1'b1; mem_addr = 32'h50;
    step();
    while (ram_req === 1'b1 && busy < 40) begin
      busy++;
      if (err === 1'b1) errs++;
      if (mem_ready !== 1'b0) errs++;
      step();
    end
    n_checks++; if (busy != 16) begin n_fail++; $display("FAIL to_busy_len: got %0d want 16", busy); end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL to_early_err: got %0d want 0", errs); end
    n_checks++; if ({err, mem_stall, mem_ready} !== 3'b110) begin n_fail++; $display("FAIL to_abort: got %b want 110", {err, mem_stall, mem_ready}); end
    step();
    n_checks++; if ({err, ram_req, ram_addr} !== {2'b01, 32'h50}) begin n_fail++; $display("FAIL to_regrant: got %b %h want 01 50", {err, ram_req}, ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h77; #1;
    reset = 1'b0; #1;
    n_checks++; if ({ram_req, ram_we, err, mem_ready, ram_addr, ram_wdata} !== 68'h0) begin n_fail++; $display("FAIL reset_mid_busy: got %b %h %h want 0", {ram_req, ram_we, err, mem_ready}, ram_addr, ram_wdata); end
    step(); mem_rd = 1'b0; ram_ack = 1'b0; reset = 1'b1;
    step();
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_no_resume: got %b want 0", ram_req); end
    $display("txn timeout on 50 after %0d busy cycles, then reset", busy);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_starvation();
    test_kill();
    test_store();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
